ram_latency_model: RTL and testbench
====================================

Name: ram_latency_model

Overview:
- Word-organised backing memory that sits behind the cache as its main-memory model.
- Accepts one read or write request at a time, detected as a change on its request inputs.
- Completes the request after a fixed programmable latency, then signals completion on `response`.
- Gives the cache a realistic miss penalty and a write-through target.

Parameters:
- DEPTH, 1024: number of 32-bit words stored.
- AW, 10: address bits used to index the array; DEPTH = 2**AW.
- LATENCY, 4: cycles from request capture to `response` rising; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- data  input  32  write data.
- addr  input  32  word address; only addr[AW-1:0] is used, upper bits are ignored (aliasing).
- wr  input  1  1 = write request, 0 = read request.
- response  output  1  1 = idle or last request complete; 0 = request in progress.
- out  output  32  read data; registered.

Behaviour:
- Internal state:
  - Latched request registers `req_data`, `req_addr`, `req_wr`.
  - Two-state FSM: IDLE, BUSY.
  - 8-bit down-counter `cnt`.
  - Memory array of DEPTH x 32 bits.
- Reset (rst=1 at a posedge):
  - state=IDLE, response=1, out=0.
  - req_data=0, req_addr=0, req_wr=0, cnt=0.
  - Memory contents are NOT cleared; for simulation they are zero-initialised at time 0.
  - Reset overrides everything, including a pending BUSY request, which is discarded with no memory write.
- Request detection:
  - Evaluated at every posedge with rst=0.
  - A new request exists when {data, addr, wr} != {req_data, req_addr, req_wr}.
  - The comparison covers the full 32-bit addr, although storage uses only the low AW bits.
  - Consequence: after reset, a read of address 0 with data=0 is not detected as a request. This is intended; the requester must change some input to start a transaction.
- Capture (a new request is detected, in any state):
  - Latch the inputs into the req_* registers.
  - response<=0, cnt<=LATENCY-1, state<=BUSY.
  - If BUSY, the in-flight request is aborted: no memory write, out unchanged. The new request restarts the latency count.
- BUSY, no new request:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0, complete the request:
    - Write (req_wr=1): mem[req_addr[AW-1:0]]<=req_data; out unchanged.
    - Read (req_wr=0): out<=mem[req_addr[AW-1:0]].
    - Then response<=1 and state<=IDLE.
- IDLE, no new request: hold all outputs.
- Latency:
  - Capture edge is edge 0; response rises and out is valid after edge LATENCY.
  - With LATENCY=1, completion happens on the edge after capture.
- Memory timing:
  - A read always sees all previously completed writes.
  - There is no read/write overlap, since only one request is in flight.
- Holding inputs stable after completion produces no further activity; response stays 1.

Test Plan:
- Reset: assert rst for 2 cycles, then release with inputs 0 -> response=1, out=0, state IDLE; 10 idle cycles leave response=1.
- Write then read:
  - wr=1, addr=5, data=0xDEADBEEF -> response=0 on the capture edge and 1 exactly 4 cycles later.
  - Then wr=0, addr=5 -> after 4 cycles response=1 and out=0xDEADBEEF.
- Aliasing: write addr=0x405, data=0x12345678, then read addr=5 -> out=0x12345678.
- Abort:
  - wr=1, addr=7, data=0xAAAA0000; after 2 cycles change to wr=0, addr=9.
  - Response rises 4 cycles after the second capture; out=mem[9].
  - A later read of addr 7 returns the old value (the write was aborted).
- Reset mid-operation: start a write to addr=3 with data=0x55; pulse rst after 1 cycle -> response=1, out=0, and a later read of addr 3 returns its pre-write value.
- Latency parameter: with LATENCY=1, a read completes on the edge after capture; with LATENCY=8, response stays 0 for exactly 8 cycles.

Source files
------------

// File: rtl/ram_latency_model.sv
// ram_latency_model
//   Word-organised main-memory model placed behind the cache. It accepts one
//   read or write request at a time. A request is recognised when the
//   {data, addr, wr} inputs differ from the last captured request. The
//   request completes LATENCY cycles after capture, and response then
//   rises again.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   data     in   [31:0] write data
//   addr     in   [31:0] word address (only addr[AW-1:0] indexes storage)
//   wr       in   1 = write request, 0 = read request
//   response out  1 = idle / last request complete, 0 = request in progress
//   out      out  [31:0] registered read data
module ram_latency_model #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t      state;
  logic [31:0] req_data;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [7:0]  cnt;

  // Contents survive reset; the initial value only exists so that
  // simulation starts from a known all-zero memory.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  logic          new_req;
  logic          complete;
  logic [AW-1:0] idx;

  // The comparison deliberately covers the full 32-bit address, so an
  // address change only in the ignored upper bits still starts a request.
  assign new_req  = ({data, addr, wr} != {req_data, req_addr, req_wr});
  assign complete = (state == BUSY) && !new_req && (cnt == 8'd0);
  assign idx      = req_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      response <= 1'b1;
      out      <= 32'h0;
      req_data <= 32'h0;
      req_addr <= 32'h0;
      req_wr   <= 1'b0;
      cnt      <= 8'h0;
    end else if (new_req) begin
      // A new request is captured in either state. In BUSY, the request in
      // flight is dropped without any side effect.
      req_data <= data;
      req_addr <= addr;
      req_wr   <= wr;
      response <= 1'b0;
      cnt      <= CNT_INIT;
      state    <= BUSY;
    end else if (state == BUSY) begin
      if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else begin
        if (!req_wr) begin
          out <= mem[idx];
        end
        response <= 1'b1;
        state    <= IDLE;
      end
    end
  end

  // Memory write happens only on the completion edge of a write request.
  // Reset or a newly captured request on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && complete && req_wr) begin
      mem[idx] <= req_data;
    end
  end

endmodule

// File: tb/tb_ram_latency_model.sv
module tb_ram_latency_model;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;

  logic        resp4, resp1, resp8;
  logic [31:0] out4, out1, out8;

  int checks = 0;
  int errors = 0;

  ram_latency_model u4 (
    .clk(clk), .rst(rst), .data(data), .addr(addr), .wr(wr),
    .response(resp4), .out(out4)
  );

  ram_latency_model #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .data(data), .addr(addr), .wr(wr),
    .response(resp1), .out(out1)
  );

  ram_latency_model #(.LATENCY(8)) u8 (
    .clk(clk), .rst(rst), .data(data), .addr(addr), .wr(wr),
    .response(resp8), .out(out8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        resp;
    logic [31:0] out;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic w, logic [31:0] a, logic [31:0] d,
                              logic rs, logic [31:0] o);
    vec_t v;
    v.rst = r; v.wr = w; v.addr = a; v.data = d; v.resp = rs; v.out = o;
    vecs.push_back(v);
  endfunction

  // One full LATENCY=4 transaction: capture edge and 3 counting edges with
  // response low, then the completion edge.
  function automatic void xact(logic w, logic [31:0] a, logic [31:0] d,
                               logic [31:0] o_before, logic [31:0] o_after);
    for (int k = 0; k < 4; k++) add(1'b0, w, a, d, 1'b0, o_before);
    add(1'b0, w, a, d, 1'b1, o_after);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wdat;

  initial begin
    rst = 1'b1; wr = 1'b0; addr = 32'h0; data = 32'h0;

    // Reset for two edges, then idle with zero inputs (not a request).
    add(1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 1, 0);

    // Write then read back address 5.
    xact(1, 32'd5, 32'hDEADBEEF, 32'h0, 32'h0);
    add(0, 1, 32'd5, 32'hDEADBEEF, 1, 32'h0);
    xact(0, 32'd5, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    add(0, 0, 32'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF);

    // Aliasing: 0x405 maps onto word 5.
    xact(1, 32'h405, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF);
    xact(0, 32'd5, 32'h12345678, 32'hDEADBEEF, 32'h12345678);

    // Abort: write to 7 replaced after 2 edges by a read of 9.
    add(0, 1, 32'd7, 32'hAAAA0000, 0, 32'h12345678);
    add(0, 1, 32'd7, 32'hAAAA0000, 0, 32'h12345678);
    xact(0, 32'd9, 32'hAAAA0000, 32'h12345678, 32'h0);
    xact(0, 32'd7, 32'hAAAA0000, 32'h0, 32'h0);

    // Make out non-zero before the mid-operation reset.
    xact(0, 32'd5, 32'h55, 32'h0, 32'h12345678);

    // Write to 3 is captured, then reset discards it.
    add(0, 1, 32'd3, 32'h55, 0, 32'h12345678);
    add(1, 1, 32'd3, 32'h55, 1, 32'h0);
    xact(0, 32'd3, 32'h55, 32'h0, 32'h0);
    add(0, 0, 32'd3, 32'h55, 1, 32'h0);
    add(0, 0, 32'd3, 32'h55, 1, 32'h0);

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      wr   = vecs[i].wr;
      addr = vecs[i].addr;
      data = vecs[i].data;
      step();
      check($sformatf("v%0d_response", i), {31'h0, resp4}, {31'h0, vecs[i].resp});
      check($sformatf("v%0d_out", i), out4, vecs[i].out);
    end

    // LATENCY=1 and LATENCY=8: write to 0x21, then read it back.
    wdat = 32'h0BADC0DE;
    wr = 1'b1; addr = 32'h21; data = wdat;
    step();
    check("lat1_wr_capture", {31'h0, resp1}, 32'h0);
    check("lat8_wr_capture", {31'h0, resp8}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("lat1_wr_k%0d", k), {31'h0, resp1}, 32'h1);
      check($sformatf("lat8_wr_k%0d", k), {31'h0, resp8}, (k == 8) ? 32'h1 : 32'h0);
    end

    wr = 1'b0;
    step();
    check("lat1_rd_capture", {31'h0, resp1}, 32'h0);
    check("lat8_rd_capture", {31'h0, resp8}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("lat1_rd_k%0d", k), {31'h0, resp1}, 32'h1);
      check($sformatf("lat1_rd_out_k%0d", k), out1, wdat);
      check($sformatf("lat8_rd_k%0d", k), {31'h0, resp8}, (k == 8) ? 32'h1 : 32'h0);
    end
    check("lat8_rd_out", out8, wdat);

    // Stable inputs after completion: no further activity.
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("lat8_hold_k%0d", k), {31'h0, resp8}, 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
